// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: score word layout, articulation
// modes, FSM states and the articulation split helper.
package note_sequencer_pkg;

  // Score word field positions
  localparam int MODE_MSB = 15;
  localparam int MODE_LSB = 14;
  localparam int TONE_MSB = 13;
  localparam int TONE_LSB = 8;
  localparam int BPM_MSB  = 7;
  localparam int BPM_LSB  = 0;
  localparam int LEN_MSB  = 3;
  localparam int LEN_LSB  = 0;

  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'b00,
    MODE_STACCATO = 2'b01,
    MODE_SLURRED  = 2'b10,
    MODE_BPM_COMM = 2'b11
  } noteMode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SOUND = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_END   = 3'd5
  } seqState_t;

  // Sound/gap lengths of one note, in 1/32-note ticks
  typedef struct packed {
    logic [5:0] soundTicks;
    logic [5:0] gapTicks;
  } noteSplit_t;

  // Split a note of 2*(len+1) ticks into sounding and silent parts.
  function automatic noteSplit_t splitNote(input noteMode_t mode, input logic [3:0] len);
    noteSplit_t split;
    logic [5:0] dur;
    logic [5:0] half;
    dur  = {1'b0, len, 1'b0} + 6'd2;
    half = {2'b00, len} + 6'd1;
    case (mode)
      MODE_NORMAL: begin
        split.soundTicks = dur - 6'd1;
        split.gapTicks   = 6'd1;
      end
      MODE_STACCATO: begin
        split.soundTicks = half;
        split.gapTicks   = half;
      end
      MODE_SLURRED: begin
        split.soundTicks = dur;
        split.gapTicks   = 6'd0;
      end
      default: begin
        split.soundTicks = 6'd0;
        split.gapTicks   = 6'd0;
      end
    endcase
    return split;
  endfunction

endpackage

// File: rtl/note_sequencer_tick_gen.sv
// Phase accumulator producing one tick per 1/32 note at the current tempo.
// A tick is flagged in the cycle whose increment crosses the threshold, so
// the consuming counter sees it on the same edge that consumes the remainder.
module note_sequencer_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       CLR,
  input  logic [7:0] BPM,
  output logic       TICK
);

  // One 1/32 note lasts 60/(8*BPM) s, i.e. 15*CLK_HZ / (2*BPM) cycles
  localparam logic [32:0] THRESH = 33'(64'd15 * 64'(CLK_HZ));

  logic [31:0] accR;
  logic [8:0]  incS;
  logic [32:0] sumS;

  assign incS = {BPM, 1'b0};
  assign sumS = {1'b0, accR} + {24'd0, incS};
  assign TICK = EN && (sumS >= THRESH);

  // Accumulate while enabled; clearing restarts the phase for a new note.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      accR <= 32'd0;
    end else if (CLR) begin
      accR <= 32'd0;
    end else if (EN) begin
      if (TICK) begin
        accR <= 32'(sumS - THRESH);
      end else begin
        accR <= sumS[31:0];
      end
    end else begin
      accR <= accR;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: takes score words over valid/ready and drives timed
// tone/volume commands, with tempo commands and articulation handling.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int         CLK_HZ  = 100_000_000,
  parameter logic [7:0] DEF_BPM = 8'd80,
  parameter logic [3:0] DEF_VOL = 4'hF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PLAY,
  input  logic [15:0] IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [5:0]  TONE,
  output logic [3:0]  VOL,
  output logic [7:0]  BPM,
  output logic        NOTE_DONE,
  output logic        SONG_END
);

  seqState_t  stateR;
  logic       inReadyR;
  logic [5:0] toneR;
  logic [3:0] volR;
  logic [7:0] bpmR;
  logic       noteDoneR;
  logic       songEndR;
  logic [5:0] tickCntR;
  logic [5:0] soundTicksR;
  logic [5:0] gapTicksR;

  logic       acceptS;
  noteMode_t  wordModeS;
  logic [5:0] wordToneS;
  logic [7:0] wordBpmS;
  logic [3:0] wordLenS;
  noteSplit_t wordSplitS;
  logic       tickEnS;
  logic       tickS;
  logic [5:0] tickNextS;
  logic [3:0] soundVolS;

  assign acceptS    = inReadyR & IN_VALID;
  assign wordModeS  = noteMode_t'(IN_DATA[MODE_MSB:MODE_LSB]);
  assign wordToneS  = IN_DATA[TONE_MSB:TONE_LSB];
  assign wordBpmS   = IN_DATA[BPM_MSB:BPM_LSB];
  assign wordLenS   = IN_DATA[LEN_MSB:LEN_LSB];
  assign wordSplitS = splitNote(wordModeS, wordLenS);

  // Time only advances while a note is playing and not paused
  assign tickEnS   = PLAY & ((stateR == ST_SOUND) | (stateR == ST_GAP));
  assign tickNextS = tickCntR + 6'd1;
  assign soundVolS = (toneR != 6'd0) ? DEF_VOL : 4'h0;

  note_sequencer_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) uTickGen (
    .CLK (CLK),
    .RST (RST),
    .EN  (tickEnS),
    .CLR (acceptS),
    .BPM (bpmR),
    .TICK(tickS)
  );

  // Sequencer FSM: word decode, per-phase tick counting and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stateR      <= ST_IDLE;
      inReadyR    <= 1'b0;
      toneR       <= 6'd0;
      volR        <= 4'h0;
      bpmR        <= DEF_BPM;
      noteDoneR   <= 1'b0;
      songEndR    <= 1'b0;
      tickCntR    <= 6'd0;
      soundTicksR <= 6'd0;
      gapTicksR   <= 6'd0;
    end else begin
      noteDoneR <= 1'b0;
      case (stateR)
        ST_IDLE: begin
          songEndR <= 1'b0;
          if (PLAY) begin
            stateR   <= ST_FETCH;
            inReadyR <= 1'b1;
          end else begin
            inReadyR <= 1'b0;
          end
        end

        ST_FETCH: begin
          if (acceptS) begin
            if (wordModeS == MODE_BPM_COMM) begin
              if (wordBpmS != 8'd0) begin
                bpmR     <= wordBpmS;
                inReadyR <= PLAY;
              end else begin
                stateR   <= ST_END;
                inReadyR <= 1'b0;
                volR     <= 4'h0;
                songEndR <= 1'b1;
              end
            end else begin
              stateR      <= ST_SOUND;
              inReadyR    <= 1'b0;
              toneR       <= wordToneS;
              soundTicksR <= wordSplitS.soundTicks;
              gapTicksR   <= wordSplitS.gapTicks;
              tickCntR    <= 6'd0;
              volR        <= (PLAY && (wordToneS != 6'd0)) ? DEF_VOL : 4'h0;
            end
          end else begin
            inReadyR <= PLAY;
          end
        end

        ST_SOUND: begin
          if (tickS && (tickNextS == soundTicksR)) begin
            tickCntR <= 6'd0;
            volR     <= 4'h0;
            if (gapTicksR != 6'd0) begin
              stateR <= ST_GAP;
            end else begin
              stateR    <= ST_DONE;
              noteDoneR <= 1'b1;
            end
          end else begin
            if (tickS) begin
              tickCntR <= tickNextS;
            end else begin
              tickCntR <= tickCntR;
            end
            volR <= PLAY ? soundVolS : 4'h0;
          end
        end

        ST_GAP: begin
          volR <= 4'h0;
          if (tickS && (tickNextS == gapTicksR)) begin
            tickCntR  <= 6'd0;
            stateR    <= ST_DONE;
            noteDoneR <= 1'b1;
          end else if (tickS) begin
            tickCntR <= tickNextS;
          end else begin
            tickCntR <= tickCntR;
          end
        end

        ST_DONE: begin
          stateR   <= ST_FETCH;
          inReadyR <= PLAY;
        end

        ST_END: begin
          inReadyR <= 1'b0;
          volR     <= 4'h0;
          if (!PLAY) begin
            stateR   <= ST_IDLE;
            songEndR <= 1'b0;
          end else begin
            songEndR <= 1'b1;
          end
        end

        default: begin
          stateR   <= ST_IDLE;
          inReadyR <= 1'b0;
          volR     <= 4'h0;
        end
      endcase
    end
  end

  assign IN_READY  = inReadyR;
  assign TONE      = toneR;
  assign VOL       = volR;
  assign BPM       = bpmR;
  assign NOTE_DONE = noteDoneR;
  assign SONG_END  = songEndR;

endmodule
